regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-port register file with an integrated per-register busy scoreboard, the next-generation general-purpose register bank for the processor core. Provides two asynchronous read ports, one writeback port and an issue port that marks destination registers busy until writeback. Register 0 is hardwired to zero. The decode stage uses busy flags and issue stalls to resolve RAW/WAW hazards on long-latency results.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; register count NREGS = 2**ADDR_W (register 0 not stored)

- clk_i  in  1  clock, rising edge
- reset_ni  in  1  reset, asynchronous, active-low
- rs_a_addr_i  in  ADDR_W  read port A address
- rs_b_addr_i  in  ADDR_W  read port B address
- rs_a_data_o  out  DATA_W  read port A data
- rs_b_data_o  out  DATA_W  read port B data
- rs_a_busy_o  out  1  register at rs_a_addr_i has a pending write
- rs_b_busy_o  out  1  register at rs_b_addr_i has a pending write
- issue_valid_i  in  1  instruction issuing with destination issue_rd_i
- issue_rd_i  in  ADDR_W  destination register of issuing instruction
- issue_ready_o  out  1  issue may be accepted this cycle
- wb_valid_i  in  1  writeback strobe
- wb_rd_i  in  ADDR_W  writeback destination
- wb_data_i  in  DATA_W  writeback data
- flush_i  in  1  clear all busy bits (pipeline flush)
- busy_count_o  out  ADDR_W  number of registers currently busy

## Operation
- Storage: registers 1..NREGS-1, DATA_W bits each; busy bit per register 1..NREGS-1; busy_count register.
- Reads: combinational from stored state. Address 0 -> data 0, busy 0.
- Issue handshake: issue_ready_o = !busy[issue_rd_i] (combinational, registered busy only); issue_rd_i = 0 -> ready 1. Accepted when issue_valid_i && issue_ready_o; sets busy[issue_rd_i] at next edge (rd 0: accepted, no effect). Valid with ready low: no state change; issuer holds.
- Writeback: wb_valid_i with wb_rd_i != 0 writes wb_data_i and clears busy[wb_rd_i] at next edge. wb_rd_i = 0 ignored. Writeback to a non-busy register is legal: data written, busy unchanged.
- Same-cycle issue and writeback, same rd (rd not busy, so issue accepted): data written, busy ends 1.
- Same-cycle issue and writeback, different rd: both take effect.
- flush_i: all busy bits and busy_count cleared at next edge; overrides any same-cycle issue set. A same-cycle writeback still writes data.
- busy_count: maintained incrementally: +1 on accepted issue setting a clear bit, -1 on writeback clearing a set bit, net 0 when both occur; 0 on flush. Must always equal popcount of busy bits; never wraps (max NREGS-1).

## Timing
- Reset (async assert): all registers 0, busy bits 0, busy_count_o 0; hence rs_*_data_o 0, rs_*_busy_o 0, issue_ready_o 1. Deassertion synchronous to clk_i externally.
- Writeback data visible on read ports the cycle after the wb edge (0-cycle with bypass, see Configuration).
- Busy set visible on rs_*_busy_o, issue_ready_o and busy_count_o the cycle after issue acceptance; cleared the cycle after writeback or flush.
- All outputs combinational from registered state and addresses/wb inputs; no internal pipeline latency.

## Configuration
- REGFILE_BYPASS_EN defined: if wb_valid_i && wb_rd_i != 0 && wb_rd_i == rs_x_addr_i, rs_x_data_o = wb_data_i and rs_x_busy_o = 0 in the same cycle. issue_ready_o is not bypassed.
- Undefined: read ports return stored state only; same-cycle writeback not visible until next cycle.

## Test plan
- Reset, then read all addresses on both ports -> data 0, busy 0, issue_ready_o 1, busy_count_o 0.
- wb rd=5 data 0xDEADBEEF; next cycle read A=5, B=0 -> A=0xDEADBEEF, B=0; wb rd=0 data 0x1 -> address 0 still reads 0.
- Issue rd=7 -> next cycle rs_a_busy_o=1 at addr 7, busy_count_o=1; issue rd=7 again -> issue_ready_o=0, count stays 1; wb rd=7 0x1234 -> next cycle busy 0, count 0, data 0x1234.
- Issue rd=3 and wb rd=9 (busy) same cycle -> count unchanged; issue rd=4 with flush_i -> all busy 0, count 0.
- Bypass: wb rd=12 0xA5A5A5A5 with read A=12 same cycle -> with REGFILE_BYPASS_EN data 0xA5A5A5A5 busy 0; without, old value until next cycle.
- Assert reset_ni low mid-sequence with 3 busy regs -> immediately data 0, busy 0, count 0, issue_ready_o 1.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, issue, writeback and flush signals of the register bank.
// master = decode/writeback side, slave = register file.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs_a_addr_i;
   logic [ADDR_W-1:0] rs_b_addr_i;
   logic [DATA_W-1:0] rs_a_data_o;
   logic [DATA_W-1:0] rs_b_data_o;
   logic              rs_a_busy_o;
   logic              rs_b_busy_o;
   logic              issue_valid_i;
   logic [ADDR_W-1:0] issue_rd_i;
   logic              issue_ready_o;
   logic              wb_valid_i;
   logic [ADDR_W-1:0] wb_rd_i;
   logic [DATA_W-1:0] wb_data_i;
   logic              flush_i;
   logic [ADDR_W-1:0] busy_count_o;

   modport master (
      output rs_a_addr_i, rs_b_addr_i, issue_valid_i, issue_rd_i,
             wb_valid_i, wb_rd_i, wb_data_i, flush_i,
      input  rs_a_data_o, rs_b_data_o, rs_a_busy_o, rs_b_busy_o,
             issue_ready_o, busy_count_o
   );

   modport slave (
      input  rs_a_addr_i, rs_b_addr_i, issue_valid_i, issue_rd_i,
             wb_valid_i, wb_rd_i, wb_data_i, flush_i,
      output rs_a_data_o, rs_b_data_o, rs_a_busy_o, rs_b_busy_o,
             issue_ready_o, busy_count_o
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with per-register busy scoreboard; REGFILE_BYPASS_EN adds wb->read bypass.
// Reads are 0-cycle, updates visible next cycle; issue_ready_o drops while the destination is busy.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic clk_i,
   input  logic reset_ni,
   regfile_scoreboard_if.slave bus
);
   localparam int NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [1:NREGS-1];
   logic [NREGS-1:1]  busy_q;
   logic [NREGS-1:1]  busy_d;
   logic [ADDR_W-1:0] busy_count_q;
   logic [ADDR_W-1:0] busy_count_d;
   logic [NREGS-1:0]  busy_vec;

   logic issue_ready;
   logic issue_acc;
   logic wb_en;
   logic wb_clears;
   logic byp_a;
   logic byp_b;

   // Bit 0 is the constant-zero register, so it is never busy.
   assign busy_vec    = {busy_q, 1'b0};
   assign issue_ready = !busy_vec[bus.issue_rd_i];
   assign issue_acc   = bus.issue_valid_i && issue_ready && (bus.issue_rd_i != '0);
   assign wb_en       = bus.wb_valid_i && (bus.wb_rd_i != '0);
   assign wb_clears   = wb_en && busy_vec[bus.wb_rd_i];

   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < NREGS; i++) begin
         if (wb_en && bus.wb_rd_i == ADDR_W'(i)) busy_d[i] = 1'b0;
         // Issue wins over a same-rd writeback: the new producer is still outstanding.
         if (issue_acc && bus.issue_rd_i == ADDR_W'(i)) busy_d[i] = 1'b1;
      end
      if (bus.flush_i) busy_d = '0;
   end

   always_comb begin
      busy_count_d = busy_count_q;
      if (bus.flush_i) begin
         busy_count_d = '0;
      end else begin
         case ({issue_acc, wb_clears})
            2'b10:   busy_count_d = busy_count_q + ADDR_W'(1);
            2'b01:   busy_count_d = busy_count_q - ADDR_W'(1);
            default: busy_count_d = busy_count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         busy_q       <= '0;
         busy_count_q <= '0;
         for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
         if (wb_en) regs_q[bus.wb_rd_i] <= bus.wb_data_i;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign byp_a = wb_en && (bus.wb_rd_i == bus.rs_a_addr_i);
   assign byp_b = wb_en && (bus.wb_rd_i == bus.rs_b_addr_i);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   always_comb begin
      bus.rs_a_data_o = '0;
      bus.rs_b_data_o = '0;
      if (byp_a)                         bus.rs_a_data_o = bus.wb_data_i;
      else if (bus.rs_a_addr_i != '0)    bus.rs_a_data_o = regs_q[bus.rs_a_addr_i];
      if (byp_b)                         bus.rs_b_data_o = bus.wb_data_i;
      else if (bus.rs_b_addr_i != '0)    bus.rs_b_data_o = regs_q[bus.rs_b_addr_i];
   end

   assign bus.rs_a_busy_o   = byp_a ? 1'b0 : busy_vec[bus.rs_a_addr_i];
   assign bus.rs_b_busy_o   = byp_b ? 1'b0 : busy_vec[bus.rs_b_addr_i];
   assign bus.issue_ready_o = issue_ready;
   assign bus.busy_count_o  = busy_count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_scoreboard;
   logic clk_i = 1'b0;
   logic reset_ni = 1'b0;
   int checks = 0;
   int errors = 0;

   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid_i = 1'b0;
      bus.issue_rd_i    = '0;
      bus.wb_valid_i    = 1'b0;
      bus.wb_rd_i       = '0;
      bus.wb_data_i     = '0;
      bus.flush_i       = 1'b0;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = rd;
      bus.wb_data_i  = d;
   endtask

   task automatic issue(input logic [4:0] rd);
      bus.issue_valid_i = 1'b1;
      bus.issue_rd_i    = rd;
   endtask

   task automatic rd(input logic [4:0] a, input logic [4:0] b);
      bus.rs_a_addr_i = a;
      bus.rs_b_addr_i = b;
      #1;
   endtask

   initial begin
      idle();
      bus.rs_a_addr_i = '0;
      bus.rs_b_addr_i = '0;
      #3;
      // Reset state across every address on both ports
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         check("rst_a_data", bus.rs_a_data_o, 32'h0);
         check("rst_b_data", bus.rs_b_data_o, 32'h0);
         check("rst_a_busy", 32'(bus.rs_a_busy_o), 32'h0);
         check("rst_b_busy", 32'(bus.rs_b_busy_o), 32'h0);
      end
      check("rst_ready", 32'(bus.issue_ready_o), 32'h1);
      check("rst_count", 32'(bus.busy_count_o), 32'h0);
      @(negedge clk_i);
      reset_ni = 1'b1;
      tick();

      // Writeback to a non-busy register, then to r0
      wb(5'd5, 32'hDEADBEEF);
      rd(5'd5, 5'd0);
`ifdef REGFILE_BYPASS_EN
      check("wb5_same_cycle", bus.rs_a_data_o, 32'hDEADBEEF);
`else
      check("wb5_same_cycle", bus.rs_a_data_o, 32'h0);
`endif
      tick();
      idle();
      rd(5'd5, 5'd0);
      check("wb5_data", bus.rs_a_data_o, 32'hDEADBEEF);
      check("r0_data_b", bus.rs_b_data_o, 32'h0);
      check("wb5_count", 32'(bus.busy_count_o), 32'h0);
      wb(5'd0, 32'h1);
      tick();
      idle();
      rd(5'd0, 5'd5);
      check("r0_after_wb", bus.rs_a_data_o, 32'h0);
      check("r0_busy", 32'(bus.rs_a_busy_o), 32'h0);

      // Issue r7, repeat issue stalls, writeback clears
      issue(5'd7);
      rd(5'd7, 5'd0);
      check("iss7_ready_pre", 32'(bus.issue_ready_o), 32'h1);
      tick();
      rd(5'd7, 5'd0);
      check("iss7_busy", 32'(bus.rs_a_busy_o), 32'h1);
      check("iss7_count", 32'(bus.busy_count_o), 32'h1);
      check("iss7_ready_stall", 32'(bus.issue_ready_o), 32'h0);
      tick();
      check("iss7_count_hold", 32'(bus.busy_count_o), 32'h1);
      idle();
      wb(5'd7, 32'h1234);
      tick();
      idle();
      rd(5'd7, 5'd0);
      check("wb7_busy", 32'(bus.rs_a_busy_o), 32'h0);
      check("wb7_count", 32'(bus.busy_count_o), 32'h0);
      check("wb7_data", bus.rs_a_data_o, 32'h1234);

      // Issue r3 with writeback of busy r9: net count unchanged
      issue(5'd9);
      tick();
      idle();
      issue(5'd3);
      wb(5'd9, 32'h99);
      tick();
      idle();
      rd(5'd3, 5'd9);
      check("mix_count", 32'(bus.busy_count_o), 32'h1);
      check("mix_busy3", 32'(bus.rs_a_busy_o), 32'h1);
      check("mix_busy9", 32'(bus.rs_b_busy_o), 32'h0);
      check("mix_data9", bus.rs_b_data_o, 32'h99);

      // Flush overrides issue; same-cycle writeback still lands
      issue(5'd4);
      wb(5'd3, 32'h33);
      bus.flush_i = 1'b1;
      tick();
      idle();
      rd(5'd3, 5'd4);
      check("flush_count", 32'(bus.busy_count_o), 32'h0);
      check("flush_busy3", 32'(bus.rs_a_busy_o), 32'h0);
      check("flush_busy4", 32'(bus.rs_b_busy_o), 32'h0);
      check("flush_data3", bus.rs_a_data_o, 32'h33);

      // Same-cycle issue and writeback to the same idle register
      issue(5'd6);
      wb(5'd6, 32'h66);
      tick();
      idle();
      rd(5'd6, 5'd0);
      check("same_rd_busy", 32'(bus.rs_a_busy_o), 32'h1);
      check("same_rd_count", 32'(bus.busy_count_o), 32'h1);
      check("same_rd_data", bus.rs_a_data_o, 32'h66);
      wb(5'd6, 32'h67);
      tick();
      idle();
      rd(5'd6, 5'd0);
      check("same_rd_clear", 32'(bus.busy_count_o), 32'h0);

      // Bypass on a busy register; issue_ready is never bypassed
      issue(5'd12);
      tick();
      idle();
      wb(5'd12, 32'hA5A5A5A5);
      bus.issue_rd_i = 5'd12;
      rd(5'd12, 5'd0);
`ifdef REGFILE_BYPASS_EN
      check("byp_data", bus.rs_a_data_o, 32'hA5A5A5A5);
      check("byp_busy", 32'(bus.rs_a_busy_o), 32'h0);
`else
      check("byp_data", bus.rs_a_data_o, 32'h0);
      check("byp_busy", 32'(bus.rs_a_busy_o), 32'h1);
`endif
      check("byp_ready", 32'(bus.issue_ready_o), 32'h0);
      tick();
      idle();
      rd(5'd12, 5'd0);
      check("byp_next_data", bus.rs_a_data_o, 32'hA5A5A5A5);
      check("byp_next_busy", 32'(bus.rs_a_busy_o), 32'h0);

      // Async reset with three busy registers
      issue(5'd1);
      tick();
      issue(5'd2);
      tick();
      issue(5'd10);
      tick();
      idle();
      rd(5'd5, 5'd10);
      check("pre_rst_count", 32'(bus.busy_count_o), 32'h3);
      check("pre_rst_busy10", 32'(bus.rs_b_busy_o), 32'h1);
      #2;
      reset_ni = 1'b0;
      bus.issue_rd_i = 5'd1;
      #1;
      check("arst_data5", bus.rs_a_data_o, 32'h0);
      check("arst_busy10", 32'(bus.rs_b_busy_o), 32'h0);
      check("arst_count", 32'(bus.busy_count_o), 32'h0);
      check("arst_ready", 32'(bus.issue_ready_o), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
